regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter NREQ, default 2, number of writeback requesters sharing the single regfile write port (legal value 2 only in this revision).
REQ-002 Port clk, input, 1, single clock; all state updates on posedge clk.
REQ-003 Port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 Ports req_valid[NREQ], input, 1 each, requester i has a writeback pending.
REQ-005 Ports req_addr[NREQ], input, 5 each, destination register of requester i.
REQ-006 Ports req_data[NREQ], input, 32 each, writeback data of requester i.
REQ-007 Ports req_ready[NREQ], output, 1 each, writeback of requester i accepted this cycle.
REQ-008 Ports iss_valid / iss_addr / iss_ready, input / input 5 / output, issue stage reserving a destination register.
REQ-009 Ports rs1_addr, rs2_addr, input, 5 each; rs1_busy, rs2_busy, output, 1 each, scoreboard query.
REQ-010 Ports wr_en, wr_addr, wr_data, output, 1/5/32, registered drive of the regfile write port.

Function
REQ-011 Accept occurs when req_valid[i] and req_ready[i] are both high; at most one req_ready SHALL be high per cycle.
REQ-012 Single valid requester is granted in the same cycle; req_ready SHALL NOT depend on anything except req_valid and the priority pointer.
REQ-013 Both valid: the requester selected by the 1-bit priority pointer wins; the pointer toggles to the loser only after a contended grant; uncontended grants leave it unchanged.
REQ-014 Accepted request appears on wr_en/wr_addr/wr_data exactly 1 cycle later; wr_en is high for exactly one cycle per accept.
REQ-015 Accept with req_addr = 0 completes the handshake but wr_en SHALL stay 0 that following cycle.
REQ-016 Scoreboard: 32 busy bits; bit 0 is hardwired 0.
REQ-017 iss_ready = !busy[iss_addr] OR (a writeback to iss_addr is accepted in the same cycle); iss_addr = 0 always ready.
REQ-018 Issue fire (iss_valid & iss_ready) sets busy[iss_addr] at the next edge.
REQ-019 Accept of a writeback clears busy[req_addr] at the next edge.
REQ-020 Simultaneous set and clear of the same bit: set wins (bit ends 1).
REQ-021 rsN_busy = busy[rsN_addr], combinational from registered state.
REQ-022 Writeback to a non-busy register is legal; written normally, scoreboard unchanged.

Reset
REQ-023 rst_n low at posedge clk: wr_en=0, wr_addr=0, wr_data=0, all busy bits 0, priority pointer=0 (requester 0 favoured).
REQ-024 During reset cycles req_ready and iss_ready SHALL be 0; reset mid-transfer discards the pending registered write (no wr_en after reset deasserts).

Configuration
REQ-025 Macro REGFILE_WB_FWD_EN: when defined, add outputs fwd1_hit/fwd1_data and fwd2_hit/fwd2_data; fwdN_hit = wr_en & (wr_addr == rsN_addr) & (rsN_addr != 0), data = wr_data; and rsN_busy SHALL read 0 on a hit.
REQ-026 Undefined: no forwarding ports exist and rsN_busy reflects the raw busy bit only.

Structure
REQ-027 Shared package regfile_pkg holds REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32 and the wb_req_t struct (valid, addr, data).
REQ-028 Sub-module rr_arb2 (2-way round-robin arbiter with pointer) is instantiated once; scoreboard and output stage stay in the top module.

Verification
REQ-029 Reset then iss x5 -> next cycle rs1_addr=5 gives rs1_busy=1, iss_ready for 5 drops to 0.
REQ-030 req0 valid addr=5 data=0xDEADBEEF alone -> req_ready[0]=1 same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; busy[5]=0 thereafter.
REQ-031 Both valid for 4 cycles (addr 3, addr 4) -> grants 0,1,0,1; no cycle with both ready.
REQ-032 Same cycle iss x7 and writeback accept to x7 while busy[7]=1 -> iss_ready=1, busy[7]=1 afterwards.
REQ-033 Writeback to x0 with data 0x1 -> req_ready=1, wr_en stays 0; rs1_addr=0 -> rs1_busy=0.
REQ-034 Pending accept then rst_n low one cycle -> wr_en=0, all busy 0, pointer 0; with REGFILE_WB_FWD_EN, wr to x9 and rs2_addr=9 -> fwd2_hit=1, rs2_busy=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the regfile writeback arbiter:
//   REG_ADDR_W - register address width
//   REG_DATA_W - register data width
//   NUM_REGS   - number of architectural registers (x0 reads as zero)
//   wb_req_t   - one writeback request (valid, destination, data)
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter with a 1-bit priority pointer.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset; pointer returns to 0, grants held low
//   req   - request vector
//   gnt   - one-hot (or zero) grant vector, purely combinational from req and
//           the pointer (and reset)
// The pointer only moves after a contended grant, and then it moves to the
// loser. Uncontended grants leave it alone.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = rst_n & req[0] & (~req[1] | ~ptr);
        gnt[1] = rst_n & req[1] & (~req[0] |  ptr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (&req) begin
            // Winner was ptr; hand priority to the other requester.
            ptr <= ~ptr;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Arbitrates NREQ writeback requesters onto the single regfile write port and
// keeps a busy scoreboard of registers reserved by the issue stage.
// Handshake: a transfer happens in a cycle where valid and ready are both
// high; ready never waits on valid being held and depends only on the
// requester valids and the arbiter pointer (plus reset).
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   req_valid/addr/data  - writeback requests; req_ready - accepted this cycle
//   iss_valid/addr       - issue stage reservation; iss_ready - may reserve
//   rs1_addr, rs2_addr   - scoreboard query; rs1_busy, rs2_busy - results
//   wr_en/addr/data      - registered regfile write port (1 cycle after accept)
// Optional feature (macro REGFILE_WB_FWD_EN): adds fwd1_hit/fwd1_data and
// fwd2_hit/fwd2_data bypass outputs; a hit masks the matching rsN_busy.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NREQ-1:0]                      req_valid,
    input  logic [NREQ-1:0][REG_ADDR_W-1:0]      req_addr,
    input  logic [NREQ-1:0][REG_DATA_W-1:0]      req_data,
    output logic [NREQ-1:0]                      req_ready,
    input  logic                                 iss_valid,
    input  logic [REG_ADDR_W-1:0]                iss_addr,
    output logic                                 iss_ready,
    input  logic [REG_ADDR_W-1:0]                rs1_addr,
    input  logic [REG_ADDR_W-1:0]                rs2_addr,
    output logic                                 rs1_busy,
    output logic                                 rs2_busy,
`ifdef REGFILE_WB_FWD_EN
    output logic                                 fwd1_hit,
    output logic [REG_DATA_W-1:0]                fwd1_data,
    output logic                                 fwd2_hit,
    output logic [REG_DATA_W-1:0]                fwd2_data,
`endif
    output logic                                 wr_en,
    output logic [REG_ADDR_W-1:0]                wr_addr,
    output logic [REG_DATA_W-1:0]                wr_data
);

    wb_req_t               reqs [NREQ];
    wb_req_t               win;
    logic [NREQ-1:0]       gnt;
    logic                  accept;
    logic                  iss_fire;
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_nxt;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            reqs[i].valid = req_valid[i];
            reqs[i].addr  = req_addr[i];
            reqs[i].data  = req_data[i];
        end
    end

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .gnt   (gnt)
    );

    assign req_ready = gnt;
    assign win       = gnt[1] ? reqs[1] : reqs[0];
    assign accept    = win.valid & (|gnt);

    // A writeback to the same register in this cycle frees it, so the issue
    // stage may re-reserve it immediately. x0 is never tracked.
    always_comb begin
        iss_ready = 1'b0;
        if (rst_n) begin
            iss_ready = (iss_addr == '0) | ~busy[iss_addr]
                      | (accept & (win.addr == iss_addr));
        end
    end

    assign iss_fire = iss_valid & iss_ready;

    // Clear first, then set, so a simultaneous set/clear leaves the bit set.
    always_comb begin
        busy_nxt = busy;
        if (accept) begin
            busy_nxt[win.addr] = 1'b0;
        end
        if (iss_fire) begin
            busy_nxt[iss_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy    <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            busy  <= busy_nxt;
            wr_en <= accept & (win.addr != '0);
            if (accept && win.addr != '0) begin
                wr_addr <= win.addr;
                wr_data <= win.data;
            end
        end
    end

`ifdef REGFILE_WB_FWD_EN
    assign fwd1_hit  = wr_en & (wr_addr == rs1_addr) & (rs1_addr != '0);
    assign fwd2_hit  = wr_en & (wr_addr == rs2_addr) & (rs2_addr != '0);
    assign fwd1_data = wr_data;
    assign fwd2_data = wr_data;
    assign rs1_busy  = busy[rs1_addr] & ~fwd1_hit;
    assign rs2_busy  = busy[rs2_addr] & ~fwd2_hit;
`else
    assign rs1_busy  = busy[rs1_addr];
    assign rs2_busy  = busy[rs2_addr];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
// Directed bench for regfile_wb_arbiter. Inputs change 1 time unit after a
// rising edge; outputs are checked before the next rising edge.
module tb_regfile_wb_arbiter;

    logic                clk;
    logic                rst_n;
    logic [1:0]          req_valid;
    logic [1:0][4:0]     req_addr;
    logic [1:0][31:0]    req_data;
    logic [1:0]          req_ready;
    logic                iss_valid;
    logic [4:0]          iss_addr;
    logic                iss_ready;
    logic [4:0]          rs1_addr;
    logic [4:0]          rs2_addr;
    logic                rs1_busy;
    logic                rs2_busy;
    logic                wr_en;
    logic [4:0]          wr_addr;
    logic [31:0]         wr_data;
`ifdef REGFILE_WB_FWD_EN
    logic                fwd1_hit;
    logic [31:0]         fwd1_data;
    logic                fwd2_hit;
    logic [31:0]         fwd2_data;
`endif

    int n_checks;
    int n_errors;

    regfile_wb_arbiter #(.NREQ(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
`ifdef REGFILE_WB_FWD_EN
        .fwd1_hit  (fwd1_hit),
        .fwd1_data (fwd1_data),
        .fwd2_hit  (fwd2_hit),
        .fwd2_data (fwd2_data),
`endif
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checker
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        req_valid = 2'b00;
        iss_valid = 1'b0;
    endtask

    task automatic drive_req(input int i, input logic [4:0] a, input logic [31:0] d);
        req_valid[i] = 1'b1;
        req_addr[i]  = a;
        req_data[i]  = d;
    endtask

    task automatic drive_iss(input logic [4:0] a);
        iss_valid = 1'b1;
        iss_addr  = a;
    endtask

    logic [1:0]  exp_gnt [4];
    logic [4:0]  exp_adr [4];

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        iss_valid = 1'b0;
        iss_addr  = '0;
        rs1_addr  = '0;
        rs2_addr  = '0;

        // Reset: outputs cleared, handshakes held low even with requests up
        tick();
        tick();
        drive_req(0, 5'd3, 32'h1);
        drive_req(1, 5'd4, 32'h2);
        drive_iss(5'd0);
        rs1_addr = 5'd5;
        settle();
        check("rst_wr_en",     {31'b0, wr_en}, 32'd0);
        check("rst_wr_addr",   {27'b0, wr_addr}, 32'd0);
        check("rst_wr_data",   wr_data, 32'd0);
        check("rst_req_ready", {30'b0, req_ready}, 32'd0);
        check("rst_iss_ready", {31'b0, iss_ready}, 32'd0);
        check("rst_rs1_busy",  {31'b0, rs1_busy}, 32'd0);
        tick();
        check("rst_no_write",  {31'b0, wr_en}, 32'd0);
        idle();
        rst_n = 1'b1;
        tick();

        // Issue reserves x5
        drive_iss(5'd5);
        settle();
        check("iss5_ready", {31'b0, iss_ready}, 32'd1);
        tick();
        idle();
        settle();
        check("rs1_busy5", {31'b0, rs1_busy}, 32'd1);
        check("iss5_blocked", {31'b0, iss_ready}, 32'd0);

        // Single writeback to x5 from requester 0
        drive_req(0, 5'd5, 32'hDEADBEEF);
        settle();
        check("wb5_ready", {30'b0, req_ready}, 32'd1);
        check("wb5_frees_iss", {31'b0, iss_ready}, 32'd1);
        tick();
        idle();
        settle();
        check("wb5_wr_en",   {31'b0, wr_en}, 32'd1);
        check("wb5_wr_addr", {27'b0, wr_addr}, 32'd5);
        check("wb5_wr_data", wr_data, 32'hDEADBEEF);
        check("wb5_cleared", {31'b0, rs1_busy}, 32'd0);
        tick();
        check("wb5_one_pulse", {31'b0, wr_en}, 32'd0);

        // Contention: alternate grants starting with requester 0
        exp_gnt[0] = 2'b01; exp_adr[0] = 5'd3;
        exp_gnt[1] = 2'b10; exp_adr[1] = 5'd4;
        exp_gnt[2] = 2'b01; exp_adr[2] = 5'd3;
        exp_gnt[3] = 2'b10; exp_adr[3] = 5'd4;
        drive_req(0, 5'd3, 32'h0000_0033);
        drive_req(1, 5'd4, 32'h0000_0044);
        for (int k = 0; k < 4; k++) begin
            settle();
            check("rr_grant", {30'b0, req_ready}, {30'b0, exp_gnt[k]});
            tick();
            check("rr_wr_en", {31'b0, wr_en}, 32'd1);
            check("rr_wr_addr", {27'b0, wr_addr}, {27'b0, exp_adr[k]});
        end
        idle();
        tick();

        // Reserve x7, then re-reserve it while its writeback lands
        drive_iss(5'd7);
        tick();
        idle();
        rs1_addr = 5'd7;
        settle();
        check("rs1_busy7", {31'b0, rs1_busy}, 32'd1);
        drive_iss(5'd7);
        drive_req(0, 5'd7, 32'h0000_0077);
        settle();
        check("x7_iss_ready", {31'b0, iss_ready}, 32'd1);
        check("x7_req_ready", {30'b0, req_ready}, 32'd1);
        tick();
        idle();
        settle();
        check("x7_set_wins", {31'b0, rs1_busy}, 32'd1);
        check("x7_wr_addr", {27'b0, wr_addr}, 32'd7);

        // Writeback to x0: handshake completes, no register write
        drive_req(1, 5'd0, 32'h1);
        settle();
        check("x0_req_ready", {30'b0, req_ready}, 32'd2);
        tick();
        idle();
        rs1_addr = 5'd0;
        drive_iss(5'd0);
        settle();
        check("x0_wr_en", {31'b0, wr_en}, 32'd0);
        check("x0_rs1_busy", {31'b0, rs1_busy}, 32'd0);
        check("x0_iss_ready", {31'b0, iss_ready}, 32'd1);
        tick();
        idle();
        settle();
        check("x0_never_busy", {31'b0, rs1_busy}, 32'd0);

        // Pointer: contended grant moves it, uncontended grant does not
        drive_req(0, 5'd1, 32'h11);
        drive_req(1, 5'd2, 32'h22);
        settle();
        check("ptr_a", {30'b0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b10;
        settle();
        check("ptr_b", {30'b0, req_ready}, 32'd2);
        tick();
        req_valid = 2'b11;
        settle();
        check("ptr_hold", {30'b0, req_ready}, 32'd2);
        tick();
        idle();
        tick();

        // Reset with a write pending: write discarded, scoreboard and pointer cleared
        drive_iss(5'd9);
        tick();
        idle();
        drive_req(0, 5'd9, 32'h99);
        drive_req(1, 5'd10, 32'hAA);
        settle();
        check("pre_rst_grant", {30'b0, req_ready}, 32'd1);
        tick();
        idle();
        check("pre_rst_wr_en", {31'b0, wr_en}, 32'd1);
        rst_n = 1'b0;
        rs1_addr = 5'd7;
        rs2_addr = 5'd9;
        tick();
        check("mid_rst_wr_en", {31'b0, wr_en}, 32'd0);
        check("mid_rst_busy7", {31'b0, rs1_busy}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_wr_en", {31'b0, wr_en}, 32'd0);
        drive_req(0, 5'd3, 32'h3);
        drive_req(1, 5'd4, 32'h4);
        settle();
        check("post_rst_ptr", {30'b0, req_ready}, 32'd1);
        tick();
        idle();
        tick();

        // Writeback to x9 lands while the issue stage re-reserves x9
        drive_iss(5'd9);
        drive_req(0, 5'd9, 32'h12345678);
        tick();
        idle();
        rs2_addr = 5'd9;
        settle();
        check("x9_wr_en", {31'b0, wr_en}, 32'd1);
`ifdef REGFILE_WB_FWD_EN
        check("fwd2_hit", {31'b0, fwd2_hit}, 32'd1);
        check("fwd2_data", fwd2_data, 32'h12345678);
        check("fwd2_masks_busy", {31'b0, rs2_busy}, 32'd0);
        tick();
        check("fwd2_gone", {31'b0, fwd2_hit}, 32'd0);
        check("x9_busy_raw", {31'b0, rs2_busy}, 32'd1);
`else
        check("x9_busy_raw", {31'b0, rs2_busy}, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
